// File: rtl/periph_bus.sv
// ---------------------------------------------------------------------------
// periph_bus -- memory-mapped peripheral slave on the CPU data bus.
//
// Register map (word offset = addr[5:2]):
//   0 TH        timer reload value (RW)
//   1 TL        timer counter (RW)
//   2 TCON      [0] enable, [1] irq enable, [2] irq status (RW)
//   3 LED       LED output register (RW)
//   4 SWITCH    board switches (RO)
//   5 DIGI      digit-scan register (RW)
//   6 UART_TXD  transmit byte (WO, reads 0)
//   7 UART_RXD  last received byte (RO, read clears rx_full / rx_ovr)
//   8 UART_CON  [0] rx_full, [1] rx_ovr, [2] tx_pend, [3] tx_busy (RO)
//   other offsets read 0 and ignore writes.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   rd, wr              read / write strobes (already qualified by addr[30])
//   addr, wdata         byte address (only [5:2] decoded), store data
//   rdata               combinational read data, 0 when rd is low
//   led, digi           output registers
//   switch              board switch input
//   irq                 registered timer interrupt request
//   rx_data, rx_valid   UART receiver byte + one-cycle valid pulse
//   tx_data, tx_start   UART transmitter byte + one-cycle start pulse
//   tx_busy             UART transmitter busy
//
// UART handshake: rx_valid is a one-cycle push with no back-pressure (a byte
// arriving while the buffer is full overwrites it and flags overrun).
// tx_start is a one-cycle launch issued only while tx_busy is low; tx_data is
// held until the next TXD write, the transmitter is expected to sample it
// on the tx_start cycle.
// ---------------------------------------------------------------------------
module periph_bus #(
  parameter int LED_W  = 8,
  parameter int SW_W   = 8,
  parameter int DIGI_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   switch,
  output logic [DIGI_W-1:0] digi,
  output logic              irq,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy
);

  localparam logic [3:0] OFF_TH   = 4'd0;
  localparam logic [3:0] OFF_TL   = 4'd1;
  localparam logic [3:0] OFF_TCON = 4'd2;
  localparam logic [3:0] OFF_LED  = 4'd3;
  localparam logic [3:0] OFF_SW   = 4'd4;
  localparam logic [3:0] OFF_DIGI = 4'd5;
  localparam logic [3:0] OFF_TXD  = 4'd6;
  localparam logic [3:0] OFF_RXD  = 4'd7;
  localparam logic [3:0] OFF_CON  = 4'd8;

  // Address decode
  logic [3:0] off;
  logic       unused_addr;

  assign off         = addr[5:2];
  // Only the word offset is decoded; the remaining address bits are ignored.
  assign unused_addr = ^{addr[31:6], addr[1:0]};

  // State registers
  logic [31:0]       th_q, th_d;
  logic [31:0]       tl_q, tl_d;
  logic [2:0]        tcon_q, tcon_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DIGI_W-1:0] digi_q, digi_d;
  logic              irq_q, irq_d;
  logic [7:0]        rxd_q, rxd_d;
  logic              rx_full_q, rx_full_d;
  logic              rx_ovr_q, rx_ovr_d;
  logic              tx_pend_q, tx_pend_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;

  // Decoded strobes
  logic wr_th, wr_tl, wr_tcon, wr_led, wr_digi, wr_txd, rd_rxd;
  logic tl_wrap;
  logic tx_launch;

  assign wr_th   = wr && (off == OFF_TH);
  assign wr_tl   = wr && (off == OFF_TL);
  assign wr_tcon = wr && (off == OFF_TCON);
  assign wr_led  = wr && (off == OFF_LED);
  assign wr_digi = wr && (off == OFF_DIGI);
  assign wr_txd  = wr && (off == OFF_TXD);
  assign rd_rxd  = rd && (off == OFF_RXD);

  assign tl_wrap = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);

  // A launch needs a pending byte, an idle transmitter, and no launch in the
  // previous cycle (tx_busy may lag tx_start by one cycle).
  assign tx_launch = tx_pend_q && !tx_busy && !tx_start_q;

  // -------------------------------------------------------------------------
  // Timer and output registers
  // -------------------------------------------------------------------------
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    led_d  = led_q;
    digi_d = digi_q;

    if (tcon_q[0]) begin
      if (tl_wrap) begin
        tl_d = th_q;
        if (tcon_q[1]) begin
          tcon_d[2] = 1'b1;
        end
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end

    // CPU writes are applied last so they override the timer update.
    if (wr_th) begin
      th_d = wdata;
    end
    if (wr_tl) begin
      tl_d = wdata;
    end
    if (wr_tcon) begin
      tcon_d = wdata[2:0];
    end
    if (wr_led) begin
      led_d = wdata[LED_W-1:0];
    end
    if (wr_digi) begin
      digi_d = wdata[DIGI_W-1:0];
    end

    // irq follows the TCON value being written, so it rises together with
    // the status bit and drops on the same edge a TCON write clears it.
    irq_d = tcon_d[1] & tcon_d[2];
  end

  // -------------------------------------------------------------------------
  // UART receive buffer
  // -------------------------------------------------------------------------
  always_comb begin
    rxd_d     = rxd_q;
    rx_full_d = rx_full_q;
    rx_ovr_d  = rx_ovr_q;

    if (rd_rxd) begin
      rx_full_d = 1'b0;
      rx_ovr_d  = 1'b0;
    end

    if (rx_valid) begin
      rxd_d     = rx_data;
      rx_full_d = 1'b1;
      // A byte arriving while the old one is being read is not an overrun.
      if (rx_full_q && !rd_rxd) begin
        rx_ovr_d = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // UART transmit buffer
  // -------------------------------------------------------------------------
  always_comb begin
    tx_data_d  = tx_data_q;
    tx_pend_d  = tx_pend_q;
    tx_start_d = tx_launch;

    if (tx_launch) begin
      tx_pend_d = 1'b0;
    end

    // A TXD write in a launch cycle keeps the new byte pending for a later
    // launch.
    if (wr_txd) begin
      tx_data_d = wdata[7:0];
      tx_pend_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Register update
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q       <= '0;
      tl_q       <= '0;
      tcon_q     <= '0;
      led_q      <= '0;
      digi_q     <= '0;
      irq_q      <= 1'b0;
      rxd_q      <= '0;
      rx_full_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
      tx_pend_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      th_q       <= th_d;
      tl_q       <= tl_d;
      tcon_q     <= tcon_d;
      led_q      <= led_d;
      digi_q     <= digi_d;
      irq_q      <= irq_d;
      rxd_q      <= rxd_d;
      rx_full_q  <= rx_full_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_pend_q  <= tx_pend_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read mux
  // -------------------------------------------------------------------------
  logic [31:0] rdata_sel;

  always_comb begin
    rdata_sel = '0;
    case (off)
      OFF_TH:   rdata_sel = th_q;
      OFF_TL:   rdata_sel = tl_q;
      OFF_TCON: rdata_sel = {29'd0, tcon_q};
      OFF_LED:  rdata_sel = 32'(led_q);
      OFF_SW:   rdata_sel = 32'(switch);
      OFF_DIGI: rdata_sel = 32'(digi_q);
      OFF_TXD:  rdata_sel = '0;
      OFF_RXD:  rdata_sel = {24'd0, rxd_q};
      OFF_CON:  rdata_sel = {28'd0, tx_busy, tx_pend_q, rx_ovr_q, rx_full_q};
      default:  rdata_sel = '0;
    endcase
  end

  assign rdata    = rd ? rdata_sel : 32'd0;
  assign led      = led_q;
  assign digi     = digi_q;
  assign irq      = irq_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

endmodule

// File: tb/tb_periph_bus.sv
// ---------------------------------------------------------------------------
// tb_periph_bus -- directed, table-driven bench for periph_bus.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// before the next rising edge.
// ---------------------------------------------------------------------------
module tb_periph_bus;

  logic        clk;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic [7:0]  switch;
  logic [11:0] digi;
  logic        irq;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;

  int checks = 0;
  int errors = 0;

  periph_bus #(.LED_W(8), .SW_W(8), .DIGI_W(12)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .led      (led),
    .switch   (switch),
    .digi     (digi),
    .irq      (irq),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  // Clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [31:0] data);
    addr  = {26'd0, off, 2'b00};
    wdata = data;
    wr    = 1'b1;
    cycle();
    wr    = 1'b0;
  endtask

  // Combinational read, no clock edge consumed.
  task automatic read_chk(input string name, input logic [3:0] off, input logic [31:0] exp);
    addr = {26'd0, off, 2'b00};
    rd   = 1'b1;
    #1;
    check(name, rdata, exp);
    rd   = 1'b0;
  endtask

  // Read with a clock edge so read side effects take place.
  task automatic read_edge(input logic [3:0] off);
    addr = {26'd0, off, 2'b00};
    rd   = 1'b1;
    cycle();
    rd   = 1'b0;
  endtask

  // Register-file vectors
  typedef struct {
    logic        do_wr;
    logic        do_rd;
    logic        chk;
    logic [3:0]  off;
    logic [31:0] wdata;
    logic [7:0]  sw;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  initial begin
    // {do_wr, do_rd, chk, off, wdata, switch, expected rdata}
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd3,  32'h0000_00A5, 8'h3C, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'd5,  32'h0000_07F1, 8'h3C, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'd3,  32'h0,         8'h3C, 32'h0000_00A5};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'd5,  32'h0,         8'h3C, 32'h0000_07F1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 4'd4,  32'h0,         8'h3C, 32'h0000_003C};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 4'd9,  32'h0,         8'h3C, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'd3,  32'h0,         8'h3C, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'd9,  32'hFFFF_FFFF, 8'h3C, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'd9,  32'h0,         8'h3C, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd3,  32'h0000_01FF, 8'h3C, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 4'd3,  32'h0,         8'h3C, 32'h0000_00FF};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 4'd5,  32'hFFFF_F123, 8'hC3, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 4'd5,  32'h0,         8'hC3, 32'h0000_0123};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 4'd4,  32'h0,         8'hC3, 32'h0000_00C3};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 4'd15, 32'h0,         8'hC3, 32'h0};
  end

  initial begin
    reset    = 1'b1;
    rd       = 1'b0;
    wr       = 1'b0;
    addr     = '0;
    wdata    = '0;
    switch   = '0;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_busy  = 1'b0;
    #1;
    repeat (3) cycle();

    // ---------------- Reset state
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_tx_start", {31'd0, tx_start}, 32'd0);
    check("reset_led", {24'd0, led}, 32'd0);
    check("reset_digi", {20'd0, digi}, 32'd0);
    reset = 1'b0;
    read_chk("reset_tl", 4'd1, 32'd0);
    read_chk("reset_tcon", 4'd2, 32'd0);
    read_chk("reset_con", 4'd8, 32'd0);
    cycle();

    // ---------------- Timer
    bus_write(4'd0, 32'hFFFF_FFFC);
    bus_write(4'd1, 32'hFFFF_FFFE);
    bus_write(4'd2, 32'h0000_0003);
    read_chk("tmr_tl_after_en", 4'd1, 32'hFFFF_FFFE);
    check("tmr_irq_0", {31'd0, irq}, 32'd0);
    cycle();
    read_chk("tmr_tl_max", 4'd1, 32'hFFFF_FFFF);
    check("tmr_irq_1", {31'd0, irq}, 32'd0);
    cycle();
    read_chk("tmr_tl_reload", 4'd1, 32'hFFFF_FFFC);
    read_chk("tmr_tcon_status", 4'd2, 32'd7);
    check("tmr_irq_set", {31'd0, irq}, 32'd1);
    bus_write(4'd2, 32'h0000_0003);
    check("tmr_irq_clr", {31'd0, irq}, 32'd0);
    read_chk("tmr_tcon_clr", 4'd2, 32'd3);
    read_chk("tmr_tl_run", 4'd1, 32'hFFFF_FFFD);
    bus_write(4'd0, 32'h0000_0010);
    read_chk("tmr_th_wr_tl", 4'd1, 32'hFFFF_FFFE);
    read_chk("tmr_th", 4'd0, 32'h0000_0010);
    cycle();
    read_chk("tmr_tl_max2", 4'd1, 32'hFFFF_FFFF);
    bus_write(4'd1, 32'h0000_1234);
    read_chk("tmr_tl_wr_wins", 4'd1, 32'h0000_1234);
    bus_write(4'd2, 32'h0000_0000);
    read_chk("tmr_tl_last", 4'd1, 32'h0000_1235);
    read_chk("tmr_tcon_off", 4'd2, 32'd0);
    check("tmr_irq_off", {31'd0, irq}, 32'd0);
    cycle();
    read_chk("tmr_tl_frozen", 4'd1, 32'h0000_1235);

    // ---------------- Register file table
    for (int i = 0; i < NVEC; i++) begin
      switch = vecs[i].sw;
      addr   = {26'd0, vecs[i].off, 2'b00};
      wdata  = vecs[i].wdata;
      wr     = vecs[i].do_wr;
      rd     = vecs[i].do_rd;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("tbl[%0d]", i), rdata, vecs[i].exp);
      end
      cycle();
      wr = 1'b0;
      rd = 1'b0;
    end
    check("led_port", {24'd0, led}, 32'h0000_00FF);
    check("digi_port", {20'd0, digi}, 32'h0000_0123);

    // ---------------- UART RX
    rx_data  = 8'h41;
    rx_valid = 1'b1;
    cycle();
    rx_data  = 8'h42;
    cycle();
    rx_valid = 1'b0;
    read_chk("rx_con_ovr", 4'd8, 32'd3);
    read_chk("rx_rxd", 4'd7, 32'h42);
    read_edge(4'd7);
    read_chk("rx_con_clr", 4'd8, 32'd0);
    rx_data  = 8'h43;
    rx_valid = 1'b1;
    cycle();
    rx_valid = 1'b0;
    read_chk("rx_con_full", 4'd8, 32'd1);
    // Read and new byte in the same cycle.
    rx_data  = 8'h44;
    rx_valid = 1'b1;
    addr     = {26'd0, 4'd7, 2'b00};
    rd       = 1'b1;
    #1;
    check("rx_same_old", rdata, 32'h43);
    cycle();
    rd       = 1'b0;
    rx_valid = 1'b0;
    read_chk("rx_same_con", 4'd8, 32'd1);
    read_chk("rx_same_new", 4'd7, 32'h44);
    read_edge(4'd7);
    read_chk("rx_drained", 4'd8, 32'd0);

    // ---------------- UART TX
    tx_busy = 1'b0;
    bus_write(4'd6, 32'hFFFF_FF55);
    check("tx_no_start_yet", {31'd0, tx_start}, 32'd0);
    read_chk("tx_pend", 4'd8, 32'd4);
    read_chk("txd_reads_0", 4'd6, 32'd0);
    cycle();
    check("tx_start_55", {31'd0, tx_start}, 32'd1);
    check("tx_data_55", {24'd0, tx_data}, 32'h55);
    cycle();
    check("tx_start_single", {31'd0, tx_start}, 32'd0);
    tx_busy = 1'b1;
    bus_write(4'd6, 32'h0000_0066);
    cycle();
    check("tx_busy_hold", {31'd0, tx_start}, 32'd0);
    read_chk("tx_busy_con", 4'd8, 32'hC);
    cycle();
    check("tx_busy_hold2", {31'd0, tx_start}, 32'd0);
    tx_busy = 1'b0;
    cycle();
    check("tx_start_66", {31'd0, tx_start}, 32'd1);
    check("tx_data_66", {24'd0, tx_data}, 32'h66);
    cycle();
    check("tx_end_66", {31'd0, tx_start}, 32'd0);
    tx_busy = 1'b1;
    bus_write(4'd6, 32'h0000_0077);
    bus_write(4'd6, 32'h0000_0088);
    check("tx_overwrite", {24'd0, tx_data}, 32'h88);
    check("tx_overwrite_nostart", {31'd0, tx_start}, 32'd0);
    tx_busy = 1'b0;
    bus_write(4'd6, 32'h0000_0099);
    check("tx_wr_launch_start", {31'd0, tx_start}, 32'd1);
    check("tx_wr_launch_data", {24'd0, tx_data}, 32'h99);
    read_chk("tx_wr_launch_pend", 4'd8, 32'd4);
    cycle();
    check("tx_gap", {31'd0, tx_start}, 32'd0);
    read_chk("tx_gap_pend", 4'd8, 32'd4);
    cycle();
    check("tx_start_99", {31'd0, tx_start}, 32'd1);
    read_chk("tx_99_con", 4'd8, 32'd0);
    cycle();
    check("tx_end_99", {31'd0, tx_start}, 32'd0);

    // ---------------- Reset mid-activity
    bus_write(4'd3, 32'h0000_005A);
    bus_write(4'd0, 32'hFFFF_FFF0);
    bus_write(4'd1, 32'hFFFF_FFFF);
    bus_write(4'd2, 32'h0000_0003);
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    tx_busy  = 1'b1;
    bus_write(4'd6, 32'h0000_00CD);
    rx_valid = 1'b0;
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    read_chk("pre_rst_con", 4'd8, 32'hD);
    tx_busy = 1'b0;
    reset   = 1'b1;
    cycle();
    reset   = 1'b0;
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_led", {24'd0, led}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    read_chk("rst_th", 4'd0, 32'd0);
    read_chk("rst_tl", 4'd1, 32'd0);
    read_chk("rst_tcon", 4'd2, 32'd0);
    read_chk("rst_rxd", 4'd7, 32'd0);
    read_chk("rst_con", 4'd8, 32'd0);
    cycle();
    read_chk("rst_tl_frozen", 4'd1, 32'd0);
    check("rst_no_launch", {31'd0, tx_start}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
